pipe_stage_reg: RTL and testbench

- Parametrised elastic pipeline register that replaces the fixed, always-advancing inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload of DATA_W bits using a valid/ready handshake, a synchronous flush and an optional 2-entry skid buffer, so stages can stall and be squashed.
- Also counts back-pressure cycles for performance debug.
- Sits between any two pipeline stages; the payload is a packed bundle of that boundary's control and data fields.

---
 rtl/pipe_stage_reg_if.sv | 31 +++
 rtl/pipe_stage_reg.sv | 137 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Interface : pipe_stage_reg_if
// Valid/ready channel, flush and status bundle for one pipe_stage_reg.
// Revision  : 1.0
// ============================================================================
interface pipe_stage_reg_if #(
  parameter int DATA_W = 72,
  parameter int CNT_W  = 16
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Elastic inter-stage register: valid/ready, flush, optional skid entry and
// a saturating back-pressure counter.
// Revision : 1.0
// ============================================================================
module pipe_stage_reg #(
  parameter int DATA_W = 72,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input logic             clk,
  input logic             reset_n,
  pipe_stage_reg_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] w_skid_q;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_accept;
  logic              w_emit;
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid;

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_emit      = w_out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Flush wins over accept and emit; data registers are left untouched.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (bus.flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt    = ST_FULL;
            w_load_main_in = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_accept) begin
            if (w_emit) begin
              w_load_main_in = 1'b1;
            end else if (SKID != 0) begin
              w_state_nxt = ST_SKID;
              w_load_skid = 1'b1;
            end
          end else if (w_emit) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (w_emit) begin
            w_state_nxt      = ST_FULL;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_main <= '0;
    end else if (w_load_main_in) begin
      r_main <= bus.in_data;
    end else if (w_load_main_skid) begin
      r_main <= w_skid_q;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] r_skid;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_skid <= '0;
        end else if (w_load_skid) begin
          r_skid <= bus.in_data;
        end
      end

      assign w_skid_q   = r_skid;
      // Decoded from the state register only, so no path from out_ready.
      assign w_in_ready = reset_n & (r_state != ST_SKID);
    end else begin : g_noskid
      logic w_skid_unused;

      assign w_skid_unused = w_load_skid;
      assign w_skid_q      = '0;
      assign w_in_ready    = reset_n & (~w_out_valid | bus.out_ready);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !bus.out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_main;
  assign bus.occupancy = r_state;
  assign bus.stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Directed bench for pipe_stage_reg in SKID=1, SKID=0 and CNT_W=4 builds.
// Revision : 1.0
// ============================================================================
module tb_pipe_stage_reg;

  logic clk;
  logic reset_n;
  int   n_total;
  int   n_bad;

  pipe_stage_reg_if #(.DATA_W(72), .CNT_W(16)) a ();
  pipe_stage_reg_if #(.DATA_W(8),  .CNT_W(16)) b ();
  pipe_stage_reg_if #(.DATA_W(8),  .CNT_W(4))  c ();

  pipe_stage_reg #(.DATA_W(72), .SKID(1), .CNT_W(16)) u_dut_skid (
    .clk(clk), .reset_n(reset_n), .bus(a)
  );
  pipe_stage_reg #(.DATA_W(8), .SKID(0), .CNT_W(16)) u_dut_noskid (
    .clk(clk), .reset_n(reset_n), .bus(b)
  );
  pipe_stage_reg #(.DATA_W(8), .SKID(1), .CNT_W(4)) u_dut_sat (
    .clk(clk), .reset_n(reset_n), .bus(c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset_n = 1'b0;
    a.flush = 1'b0; a.in_valid = 1'b0; a.in_data = '0; a.out_ready = 1'b0;
    b.flush = 1'b0; b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b0;
    c.flush = 1'b0; c.in_valid = 1'b0; c.in_data = '0; c.out_ready = 1'b0;
    repeat (2) step();

    chk("rst_out_valid", a.out_valid, 0);
    chk("rst_in_ready",  a.in_ready,  0);
    chk("rst_occ",       a.occupancy, 0);
    chk("rst_stall",     a.stall_cnt, 0);
    chk("rst_data",      a.out_data,  0);
    reset_n = 1'b1;
    #1 chk("rel_in_ready", a.in_ready, 1);

    // Streaming with downstream always ready
    a.out_ready = 1'b1;
    a.in_valid  = 1'b1;
    a.in_data   = 72'h11; step();
    chk("s1_valid", a.out_valid, 1);
    chk("s1_data",  a.out_data, 72'h11);
    chk("s1_occ",   a.occupancy, 1);
    a.in_data = 72'h22; step();
    chk("s2_data",  a.out_data, 72'h22);
    chk("s2_occ",   a.occupancy, 1);
    a.in_data = 72'h33; step();
    chk("s3_data",  a.out_data, 72'h33);
    a.in_data = 72'hA5_0000_0000_0000_005A; step();
    chk("s4_wide",  a.out_data, 72'hA5_0000_0000_0000_005A);
    a.in_valid = 1'b0; step();
    chk("s5_empty", a.out_valid, 0);
    chk("s5_stall", a.stall_cnt, 0);

    // Back-pressure fills the skid entry
    a.out_ready = 1'b0;
    a.in_valid  = 1'b1;
    a.in_data   = 72'h0A; step();
    chk("bp1_occ",   a.occupancy, 1);
    chk("bp1_ready", a.in_ready, 1);
    chk("bp1_stall", a.stall_cnt, 0);
    a.in_data = 72'h0B; step();
    chk("bp2_occ",   a.occupancy, 2);
    chk("bp2_ready", a.in_ready, 0);
    chk("bp2_data",  a.out_data, 72'h0A);
    chk("bp2_stall", a.stall_cnt, 1);
    a.in_data = 72'h0C; step();
    chk("bp3_occ",   a.occupancy, 2);
    chk("bp3_stall", a.stall_cnt, 2);
    a.in_valid  = 1'b0;
    a.out_ready = 1'b1; step();
    chk("bp4_data",  a.out_data, 72'h0B);
    chk("bp4_occ",   a.occupancy, 1);
    chk("bp4_ready", a.in_ready, 1);
    chk("bp4_stall", a.stall_cnt, 2);
    step();
    chk("bp5_valid", a.out_valid, 0);

    // Flush while holding two entries with a third offered
    a.out_ready = 1'b0;
    a.in_valid  = 1'b1;
    a.in_data   = 72'h0A; step();
    a.in_data   = 72'h0B; step();
    chk("fl0_occ", a.occupancy, 2);
    a.in_data = 72'h0C;
    a.flush   = 1'b1; step();
    chk("fl1_valid", a.out_valid, 0);
    chk("fl1_occ",   a.occupancy, 0);
    chk("fl1_stall", a.stall_cnt, 4);
    a.flush     = 1'b0;
    a.in_valid  = 1'b0;
    a.out_ready = 1'b1; step();
    chk("fl2_valid", a.out_valid, 0);
    chk("fl2_stall", a.stall_cnt, 4);

    // Asynchronous reset mid-cycle while full
    a.out_ready = 1'b0;
    a.in_valid  = 1'b1;
    a.in_data   = 72'h5A; step();
    a.in_data   = 72'h5B; step();
    a.in_valid  = 1'b0;
    chk("ar0_occ", a.occupancy, 2);
    #2 reset_n = 1'b0;
    #1;
    chk("ar1_valid", a.out_valid, 0);
    chk("ar1_occ",   a.occupancy, 0);
    chk("ar1_stall", a.stall_cnt, 0);
    chk("ar1_ready", a.in_ready, 0);
    chk("ar1_data",  a.out_data, 0);
    step();
    chk("ar2_ready", a.in_ready, 0);
    reset_n = 1'b1;
    #1 chk("ar3_ready", a.in_ready, 1);

    // SKID=0 pass-through
    b.out_ready = 1'b1;
    b.in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b.in_data = 8'(i);
      #1 chk("ns_ready", b.in_ready, 1);
      step();
      chk("ns_valid", b.out_valid, 1);
      chk("ns_data",  b.out_data, 72'(i));
    end
    b.in_valid  = 1'b0;
    b.out_ready = 1'b0;
    #1 chk("ns_drop_ready", b.in_ready, 0);
    chk("ns_drop_valid", b.out_valid, 1);
    b.out_ready = 1'b1;
    #1 chk("ns_rise_ready", b.in_ready, 1);
    step();
    chk("ns_empty", b.out_valid, 0);

    // Saturating stall counter, CNT_W=4
    c.out_ready = 1'b0;
    c.in_valid  = 1'b1;
    c.in_data   = 8'h77; step();
    c.in_valid  = 1'b0;
    chk("sat0", c.stall_cnt, 0);
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("sat_cnt", c.stall_cnt, (k > 15) ? 72'd15 : 72'(k));
    end
    chk("sat_valid", c.out_valid, 1);
    chk("sat_data",  c.out_data, 72'h77);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
